// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan multiplexer: blank pattern,
// FSM state encoding and the hex-to-glyph decode.
package sseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  // Active-low segment bits {a,b,c,d,e,f,g} for one hex digit
  function automatic logic [6:0] hex_glyph(input logic [3:0] i_digit);
    logic [6:0] v_glyph;
    case (i_digit)
      4'h0: v_glyph = 7'h01;
      4'h1: v_glyph = 7'h4F;
      4'h2: v_glyph = 7'h12;
      4'h3: v_glyph = 7'h06;
      4'h4: v_glyph = 7'h4C;
      4'h5: v_glyph = 7'h24;
      4'h6: v_glyph = 7'h20;
      4'h7: v_glyph = 7'h0F;
      4'h8: v_glyph = 7'h00;
      4'h9: v_glyph = 7'h04;
      4'hA: v_glyph = 7'h08;
      4'hB: v_glyph = 7'h60;
      4'hC: v_glyph = 7'h31;
      4'hD: v_glyph = 7'h42;
      4'hE: v_glyph = 7'h30;
      default: v_glyph = 7'h38;
    endcase
    return v_glyph;
  endfunction

endpackage

// File: rtl/sseg_scan_mux_prescaler.sv
// Refresh prescaler: per-digit slot counter with wrap strobe and a flag
// telling whether the upcoming counter value falls in the guard interval.
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV  = 65536,
  parameter int unsigned GUARD_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_slot_wrap_c,
  output logic o_in_guard_c
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Next counter value; holds while disabled
  always_comb begin
    w_cnt_next    = r_cnt;
    o_slot_wrap_c = 1'b0;
    if (i_en) begin
      if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        o_slot_wrap_c = 1'b1;
        w_cnt_next    = '0;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_in_guard_c = (w_cnt_next < CNT_W'(GUARD_CYCLES));

  // Slot counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver. Snapshots the hex word
// once per frame, scans one digit per refresh slot with a guard interval at
// each digit change, and drives active-low anode and segment pins.
// Optional build macro SSEG_LEADING_ZERO_BLANK_EN: auto-blank leading zeros
// (digit 0 is never auto-blanked).
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 65536,
  parameter int unsigned GUARD_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   hex_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  output logic [N_DIGITS-1:0]     an,
  output logic [7:0]              sseg,
  output logic                    frame_tick
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  logic                  w_slot_wrap;
  logic                  w_in_guard;
  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_rst_d;
  logic                  r_frame_pend;
  logic [4*N_DIGITS-1:0] r_hex;
  logic [N_DIGITS-1:0]   r_dp;
  logic [N_DIGITS-1:0]   r_blank;
  logic [N_DIGITS-1:0]   w_blank_snap;
  logic                  w_frame_end;
  logic                  w_snap;
  logic [3:0]            w_digit;
  logic                  w_dp_cur;
  logic                  w_blank_cur;
  logic [N_DIGITS-1:0]   w_anode;

  refresh_prescaler #(
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_prescaler (
    .clk           (clk),
    .reset         (reset),
    .i_en          (en),
    .o_slot_wrap_c (w_slot_wrap),
    .o_in_guard_c  (w_in_guard)
  );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] w_lz_mask;

  // Mark zero digits above the highest nonzero digit; digit 0 always shown
  always_comb begin
    logic v_seen;
    v_seen    = 1'b0;
    w_lz_mask = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (hex_in[4*i +: 4] != 4'h0) v_seen = 1'b1;
      if (!v_seen) w_lz_mask[i] = 1'b1;
    end
  end

  assign w_blank_snap = blank_in | w_lz_mask;
`else
  assign w_blank_snap = blank_in;
`endif

  assign w_frame_end = w_slot_wrap && (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_snap      = r_rst_d | w_frame_end;

  assign w_digit     = 4'(r_hex >> {r_idx, 2'b00});
  assign w_dp_cur    = 1'(r_dp >> r_idx);
  assign w_blank_cur = 1'(r_blank >> r_idx);
  assign w_anode     = ~(N_DIGITS'(1) << r_idx);

  // Next-state logic: disable wins, otherwise follow the slot position
  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_GUARD;
        ST_GUARD,
        ST_DRIVE: w_state_next = w_in_guard ? ST_GUARD : ST_DRIVE;
        default:  w_state_next = ST_GUARD;
      endcase
    end
  end

  // State, digit index and frame-wrap bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_GUARD;
      r_idx        <= '0;
      r_rst_d      <= 1'b1;
      r_frame_pend <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rst_d      <= 1'b0;
      r_frame_pend <= w_frame_end;
      if (w_slot_wrap) begin
        r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Frame snapshot of display data, taken at frame start and after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex   <= '0;
      r_dp    <= '0;
      r_blank <= '0;
    end else if (w_snap) begin
      r_hex   <= hex_in;
      r_dp    <= dp_in;
      r_blank <= w_blank_snap;
    end
  end

  // Registered pin drive; blank whenever disabled or outside DRIVE
  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= '1;
      sseg       <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= r_frame_pend;
      if (en && (r_state == ST_DRIVE)) begin
        an   <= w_anode;
        sseg <= w_blank_cur ? SEG_BLANK : {~w_dp_cur, hex_glyph(w_digit)};
      end else begin
        an   <= '1;
        sseg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed self-checking bench for sseg_scan_mux (4 digits, 8-cycle slots,
// 2-cycle guard). Honours SSEG_LEADING_ZERO_BLANK_EN when defined.
module tb_sseg_scan_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sseg_scan_mux #(
    .N_DIGITS     (4),
    .REFRESH_DIV  (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
    chk({tag, "_an"}, 32'(an), 32'(exp_an));
    chk({tag, "_sseg"}, 32'(sseg), 32'(exp_seg));
  endtask

  // Three reset cycles; the next tick() is the first edge after release
  task automatic do_reset(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl);
    reset    = 1'b1;
    en       = 1'b1;
    hex_in   = h;
    dp_in    = dp;
    blank_in = bl;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] scan_tbl [4];
    logic [3:0] e_an;
    logic [7:0] e_seg;
    int p;
    int d;

    // Reset behaviour
    reset    = 1'b1;
    en       = 1'b1;
    hex_in   = 16'h1234;
    dp_in    = 4'b0000;
    blank_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pins("rst", 4'b1111, 8'hFF);
      chk("rst_tick", 32'(frame_tick), 32'd0);
    end
    reset = 1'b0;
    tick();
    chk_pins("rst_first", 4'b1111, 8'hFF);
    chk("rst_first_tick", 32'(frame_tick), 32'd0);

    // Scan order: F, A, 2 with dp, 1
    scan_tbl[0] = 8'hB8;
    scan_tbl[1] = 8'h88;
    scan_tbl[2] = 8'h12;
    scan_tbl[3] = 8'hCF;
    do_reset(16'h12AF, 4'b0100, 4'b0000);
    for (int t = 1; t <= 66; t++) begin
      tick();
      p = (t - 1) % 8;
      d = ((t - 1) / 8) % 4;
      e_an  = (p < 2) ? 4'b1111 : ~(4'b0001 << d);
      e_seg = (p < 2) ? 8'hFF : scan_tbl[d];
      chk_pins("scan", e_an, e_seg);
      chk("scan_tick", 32'(frame_tick), 32'((t > 1) && ((t - 1) % 32 == 0)));
    end

    // Mid-frame input change is deferred to the next frame
    do_reset(16'h1234, 4'b0000, 4'b0000);
    for (int t = 1; t <= 36; t++) begin
      tick();
      if (t == 20) chk_pins("snap_d2", 4'b1011, 8'h92);
      if (t == 28) chk_pins("snap_d3", 4'b0111, 8'hCF);
      if (t == 35) chk_pins("snap_next_d0", 4'b1110, 8'h80);
      if (t == 18) hex_in = 16'h5678;
    end

    // Enable drop during digit 1 DRIVE and resume
    do_reset(16'h1234, 4'b0000, 4'b0000);
    for (int t = 1; t <= 24; t++) begin
      tick();
      case (t)
        12, 20, 21: chk_pins("en_d1", 4'b1101, 8'h86);
        13, 14, 15, 16, 17: chk_pins("en_off", 4'b1111, 8'hFF);
        18, 19, 22, 23: chk_pins("en_guard", 4'b1111, 8'hFF);
        24: chk_pins("en_d2", 4'b1011, 8'h92);
        default: ;
      endcase
      if (t >= 13 && t <= 24) chk("en_tick", 32'(frame_tick), 32'd0);
      if (t == 12) en = 1'b0;
      if (t == 17) en = 1'b1;
    end

    // Force-blank digit 1 with its decimal point requested
    do_reset(16'h1234, 4'b0010, 4'b0010);
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 3) chk_pins("blk_d0", 4'b1110, 8'hCC);
      if (t == 11) chk_pins("blk_d1", 4'b1101, 8'hFF);
    end

    // Leading zeros: blanked only with the optional feature built in
    do_reset(16'h0050, 4'b0000, 4'b0000);
    for (int t = 1; t <= 28; t++) begin
      tick();
      if (t == 3) chk_pins("lz_d0", 4'b1110, 8'h81);
      if (t == 11) chk_pins("lz_d1", 4'b1101, 8'hA4);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      if (t == 19) chk_pins("lz_d2", 4'b1011, 8'hFF);
      if (t == 27) chk_pins("lz_d3", 4'b0111, 8'hFF);
`else
      if (t == 19) chk_pins("lz_d2", 4'b1011, 8'h81);
      if (t == 27) chk_pins("lz_d3", 4'b0111, 8'h81);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
